// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment display path.
// Also used by the BCD display path, whose blank code is 4'hF.
package sseg_pkg;

    localparam int NUM_DIG = 4;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam digit_t BLANK_CODE = 4'hF;
    localparam seg_t   SEG_OFF    = 7'h7F;

    // Active-low anode pattern with only digit idx enabled.
    function automatic logic [NUM_DIG-1:0] anode_sel(input logic [1:0] idx);
        anode_sel = ~(NUM_DIG'(1) << idx);
    endfunction

endpackage

// File: rtl/sseg_dec.sv
// Digit code to active-low segment vector, seg[0]=a ... seg[6]=g.
// Codes 0-9 and A-E give the usual glyphs; BLANK_CODE turns every segment off.
module sseg_dec
    import sseg_pkg::*;
(
    input  digit_t code,
    output seg_t   seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sseg_scan_drv.sv
// Four-digit multiplexed seven-segment scanner with anti-ghosting guard.
// Define SSEG_DIM_EN to add the 3-bit bright input for PWM dimming.
module sseg_scan_drv
    import sseg_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 16
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
`ifdef SSEG_DIM_EN
    input  logic [2:0] bright,
`endif
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    // At least 3 bits so pcnt[2:0] always exists for the dimming compare.
    localparam int PW = ($clog2(CLK_DIV) < 3) ? 3 : $clog2(CLK_DIV);
    localparam logic [PW-1:0] TC_CNT    = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GUARD_CNT = PW'(GUARD);

    generate
        if (CLK_DIV < 2 || GUARD < 0 || GUARD >= CLK_DIV) begin : g_param_err
            $error("sseg_scan_drv: need CLK_DIV >= 2 and 0 <= GUARD < CLK_DIV");
        end
    endgenerate

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic          slot_tick;
    logic          frame_wrap;
    logic          anode_on;
    digit_t        cur_digit;
    seg_t          cur_seg;

    assign slot_tick  = (pcnt == TC_CNT);
    assign frame_wrap = slot_tick && (idx == 2'd3);
    assign cur_digit  = shadow[{idx, 2'b00} +: 4];

`ifdef SSEG_DIM_EN
    assign anode_on = (pcnt >= GUARD_CNT) && (pcnt[2:0] <= bright);
`else
    assign anode_on = (pcnt >= GUARD_CNT);
`endif

    sseg_dec u_dec (
        .code (cur_digit),
        .seg  (cur_seg)
    );

    // Shadow only reloads at the 3->0 wrap so one frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            idx        <= 2'd0;
            shadow     <= {NUM_DIG{BLANK_CODE}};
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            pcnt       <= slot_tick ? '0 : pcnt + PW'(1);
            if (slot_tick)
                idx <= idx + 2'd1;
            if (frame_wrap)
                shadow <= {d3, d2, d1, d0};
            frame_tick <= frame_wrap;
            an         <= anode_on ? anode_sel(idx) : 4'b1111;
            seg        <= cur_seg;
        end
    end

endmodule

// File: doc/sseg_scan_drv.md
SSEG_SCAN_DRV -- requirements
Module: sseg_scan_drv

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: clocks per digit slot.
REQ-002 SHALL have parameter GUARD, default 16: anode-off clocks at the start of each slot (anti-ghosting).
REQ-003 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports d3, d2, d1, d0, input, 4 each: digit codes; 0-9 decimal, A-E hex, F blank (matches the BCD converter's blank code).
REQ-006 SHALL have port an, output, 4: anodes, active-low, an[i] selects digit i.
REQ-007 SHALL have port seg, output, 7: segments, active-low, seg[0]=a ... seg[6]=g.
REQ-008 SHALL have port frame_tick, output, 1: one-clock pulse per completed 4-digit scan.

Function
REQ-009 SHALL run prescaler pcnt 0..CLK_DIV-1 and wrap to 0; slot tick asserts when pcnt==CLK_DIV-1.
REQ-010 SHALL advance digit index idx 0->1->2->3->0 on each slot tick.
REQ-011 SHALL load shadow register {d3,d2,d1,d0} only on the tick where idx wraps 3->0, so a frame never mixes old and new digits.
REQ-012 SHALL assert frame_tick for exactly one clock on that same wrap tick; period is 4*CLK_DIV clocks.
REQ-013 SHALL register an and seg, reflecting idx/pcnt/shadow state of the previous cycle: one clock of latency.
REQ-014 SHALL drive an=4'b1111 while pcnt<GUARD; otherwise drive an[idx]=0 with other anodes 1.
REQ-015 SHALL decode shadow digit idx into seg: 0..9, A,b,C,d,E standard glyphs; code F gives seg=7'h7F.
REQ-016 SHALL still sweep the anode for blank (F) digits; only seg is blanked.
REQ-017 SHALL produce no X on outputs for any input code.
REQ-018 SHALL treat CLK_DIV<2 or GUARD>=CLK_DIV as an elaboration error.

Reset
REQ-019 SHALL, on rst_n low, immediately force pcnt=0, idx=0, shadow=16'hFFFF, an=4'b1111, seg=7'h7F, frame_tick=0, regardless of slot position.
REQ-020 SHALL begin the first slot (idx 0, guard active) on the first clock after rst_n deasserts.

Configuration
REQ-021 SHALL, with SSEG_DIM_EN defined, add input bright (3 bits) and keep an=4'b1111 whenever pcnt[2:0]>bright, in addition to REQ-014; bright=7 gives full duty.
REQ-022 SHALL, without SSEG_DIM_EN, omit bright and behave as full duty.

Structure
REQ-023 SHALL take from shared package sseg_pkg: BLANK_CODE=4'hF, SEG_OFF=7'h7F, NUM_DIG=4, and the digit-code and segment-vector typedefs.
REQ-024 SHALL place the code-to-segment decoder in combinational sub-module sseg_dec, which the BCD display path reuses.

Verification (CLK_DIV=8, GUARD=2)
REQ-025 SHALL check reset: assert rst_n low mid-slot; an=1111, seg=7F, frame_tick=0 on the same edge, with no clock needed.
REQ-026 SHALL check decode: d3..d0=F,F,4,2 loaded at frame wrap; digit0 seg=7'h24, digit1 seg=7'h19, digits 2-3 seg=7'h7F with an still sweeping 1110,1101,1011,0111.
REQ-027 SHALL check tear-free update: change d0 2->7 while idx=1; digit0 shows 7'h24 for the rest of the frame, then 7'h78 after the next wrap.
REQ-028 SHALL check guard: an=1111 for 2 clocks after every slot tick (+1 register latency), then one anode low for 6 clocks.
REQ-029 SHALL check frame_tick: pulses are exactly 32 clocks apart and coincide with idx 3->0.
REQ-030 SHALL check dimming (SSEG_DIM_EN, bright=3): an is low only when GUARD<=pcnt and pcnt[2:0]<=3; with bright=7 the result matches the non-dimmed build.
